dmem_arbiter: RTL and testbench

- Sequences and shares the single-port word-addressed DataMemory between two requesters: port 0 is the CPU load/store path, port 1 is the debug/DMA path.
- Arbitrates round-robin between the two ports.
- Performs RISC-V byte/half/word loads with sign or zero extension.
- Converts sub-word stores into read-modify-write (RMW) sequences, because the memory supports only full-word WE.

---
 rtl/dmem_arbiter_if.sv | 30 +++
 rtl/dmem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Request/response/memory bundle for dmem_arbiter; port p of each packed
// request field occupies its p-th slice.
interface dmem_arbiter_if #(
  parameter int MEM_AW = 5
);
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        req_we;
  logic [5:0]        req_funct3;
  logic [63:0]       req_addr;
  logic [63:0]       req_wdata;
  logic [1:0]        rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wd;
  logic [31:0]       mem_rd;
  logic              busy;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wd, busy
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wd, busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin DataMemory sequencer: RISC-V loads with extension,
// sub-word stores as read-modify-write. Optional macro: DMEM_BOUNDS_CHECK_EN.
module dmem_arbiter #(
  parameter int MEM_AW = 5
) (
  input logic           CLK,
  input logic           RST,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WRITE, S_RESP} state_t;

  state_t              r_state;
  logic                r_last_grant;
  logic                r_grant;
  logic                r_we;
  logic [2:0]          r_f3;
  logic [MEM_AW+1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_merge;
  logic [31:0]         r_rdata;
  logic                r_err;

  logic                w_grant_any;
  logic                w_grant;
  logic [2:0]          w_sel_f3;
  logic [MEM_AW+1:0]   w_sel_addr;
  logic [31:0]         w_sel_wdata;
  logic                w_f3_ok;
  logic                w_misal;
  logic                w_oob;
  logic                w_err;
  logic                w_is_sw;
  logic [31:0]         w_shift;
  logic [31:0]         w_load;
  logic [31:0]         w_merged;

  always_comb begin
    w_grant_any = 1'b0;
    w_grant     = 1'b0;
    if (r_state == S_IDLE) begin
      case (bus.req_valid)
        2'b01:   begin w_grant_any = 1'b1; w_grant = 1'b0;          end
        2'b10:   begin w_grant_any = 1'b1; w_grant = 1'b1;          end
        2'b11:   begin w_grant_any = 1'b1; w_grant = ~r_last_grant; end
        default: begin w_grant_any = 1'b0; w_grant = 1'b0;          end
      endcase
    end
  end

  assign bus.req_ready = w_grant_any ? (w_grant ? 2'b10 : 2'b01) : 2'b00;

  assign w_sel_f3    = w_grant ? bus.req_funct3[5:3] : bus.req_funct3[2:0];
  assign w_sel_addr  = w_grant ? bus.req_addr[32 +: MEM_AW+2] : bus.req_addr[0 +: MEM_AW+2];
  assign w_sel_wdata = w_grant ? bus.req_wdata[63:32] : bus.req_wdata[31:0];

`ifdef DMEM_BOUNDS_CHECK_EN
  // Upper address bits are judged at accept time so only the flag is kept.
  logic r_oob;
  logic w_sel_oob;
  assign w_sel_oob = w_grant ? (|bus.req_addr[63:MEM_AW+34]) : (|bus.req_addr[31:MEM_AW+2]);
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      r_oob <= 1'b0;
    else if (w_grant_any)
      r_oob <= w_sel_oob;
  end
  assign w_oob = r_oob;
`else
  assign w_oob = 1'b0;
`endif

  always_comb begin
    if (r_we)
      w_f3_ok = (r_f3 == 3'b000) || (r_f3 == 3'b001) || (r_f3 == 3'b010);
    else
      w_f3_ok = (r_f3 == 3'b000) || (r_f3 == 3'b001) || (r_f3 == 3'b010) ||
                (r_f3 == 3'b100) || (r_f3 == 3'b101);
  end

  assign w_misal = ((r_f3[1:0] == 2'b01) && r_addr[0]) ||
                   ((r_f3[1:0] == 2'b10) && (r_addr[1:0] != 2'b00));
  assign w_err   = !w_f3_ok || w_misal || w_oob;
  assign w_is_sw = r_we && (r_f3 == 3'b010) && !w_err;

  assign w_shift = bus.mem_rd >> {r_addr[1:0], 3'b000};

  always_comb begin
    case (r_f3)
      3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b100:  w_load = {24'd0, w_shift[7:0]};
      3'b101:  w_load = {16'd0, w_shift[15:0]};
      default: w_load = w_shift;
    endcase
  end

  always_comb begin
    w_merged = bus.mem_rd;
    if (r_f3[0]) begin
      if (r_addr[1]) w_merged[31:16] = r_wdata[15:0];
      else           w_merged[15:0]  = r_wdata[15:0];
    end else begin
      case (r_addr[1:0])
        2'd0:    w_merged[7:0]   = r_wdata[7:0];
        2'd1:    w_merged[15:8]  = r_wdata[7:0];
        2'd2:    w_merged[23:16] = r_wdata[7:0];
        default: w_merged[31:24] = r_wdata[7:0];
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_we         <= 1'b0;
      r_f3         <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_merge      <= '0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_any) begin
            r_grant      <= w_grant;
            r_last_grant <= w_grant;
            r_we         <= bus.req_we[w_grant];
            r_f3         <= w_sel_f3;
            r_addr       <= w_sel_addr;
            r_wdata      <= w_sel_wdata;
            r_state      <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_err <= w_err;
          if (w_err || r_we) r_rdata <= '0;
          else               r_rdata <= w_load;
          // Sub-word stores take the extra WRITE cycle with the merged word.
          if (!w_err && r_we && (r_f3 != 3'b010)) begin
            r_merge <= w_merged;
            r_state <= S_WRITE;
          end else begin
            r_state <= S_RESP;
          end
        end
        S_WRITE: r_state <= S_RESP;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_addr  = r_addr[MEM_AW+1:2];
  assign bus.mem_we    = ((r_state == S_ACCESS) && w_is_sw) || (r_state == S_WRITE);
  assign bus.mem_wd    = (r_state == S_WRITE) ? r_merge :
                         ((r_state == S_ACCESS) && w_is_sw) ? r_wdata : '0;
  assign bus.rsp_valid = (r_state == S_RESP) ? (r_grant ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;
  assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: table of single transactions plus
// sequences for drop, mid-RMW reset and round-robin alternation.
module tb_dmem_arbiter;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   total = 0;
  int   bad   = 0;

  dmem_arbiter_if #(.MEM_AW(5)) mif ();

  dmem_arbiter #(.MEM_AW(5)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (mif)
  );

  always #5 CLK = ~CLK;

  logic [31:0] mem [32];
  assign mif.mem_rd = mem[mif.mem_addr];
  always @(posedge CLK) if (mif.mem_we) mem[mif.mem_addr] <= mif.mem_wd;

  typedef struct {
    int          port;
    bit          we;
    bit [2:0]    f3;
    bit [31:0]   addr;
    bit [31:0]   wdata;
    bit [31:0]   exp_rdata;
    bit          exp_err;
    int          exp_lat;
    int          exp_wecyc;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(int port, bit we, bit [2:0] f3, bit [31:0] addr,
                              bit [31:0] wdata, bit [31:0] rdata, bit err,
                              int lat, int wec);
    vec_t v;
    v.port = port; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = rdata; v.exp_err = err; v.exp_lat = lat; v.exp_wecyc = wec;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input int p, input bit v, input bit we, input bit [2:0] f3,
                       input bit [31:0] addr, input bit [31:0] wd);
    mif.req_valid[p]          = v;
    mif.req_we[p]             = we;
    mif.req_funct3[3*p +: 3]  = f3;
    mif.req_addr[32*p +: 32]  = addr;
    mif.req_wdata[32*p +: 32] = wd;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    bit got;
    int k, lat, we_cnt, we_cyc;
    logic [31:0] rd;
    logic er;
    string tag;
    tag = $sformatf("v%0d", idx);
    drive(v.port, 1'b1, v.we, v.f3, v.addr, v.wdata);
    #1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (mif.req_ready[v.port]) got = 1'b1;
      else begin @(negedge CLK); #1; end
    end
    check({tag, "_accept"}, {31'd0, got}, 32'd1);
    if (!got) begin
      drive(v.port, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      return;
    end
    @(negedge CLK);
    k = 1;
    drive(v.port, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    lat = 0; we_cnt = 0; we_cyc = 0; rd = '0; er = 1'b0;
    while (k <= 6 && lat == 0) begin
      if (mif.mem_we) begin we_cnt++; we_cyc = k; end
      if (mif.rsp_valid[v.port]) begin
        lat = k; rd = mif.rsp_rdata; er = mif.rsp_err;
      end else begin
        @(negedge CLK); k++;
      end
    end
    check({tag, "_lat"},   lat,        v.exp_lat);
    check({tag, "_rdata"}, rd,         v.exp_rdata);
    check({tag, "_err"},   {31'd0, er}, {31'd0, v.exp_err});
    check({tag, "_wecnt"}, we_cnt,     (v.exp_wecyc != 0) ? 1 : 0);
    check({tag, "_wecyc"}, we_cyc,     v.exp_wecyc);
  endtask

  initial begin
    int cnt_we, cnt_r1, cnt_v1, ngr, n11;
    int grants[4];

    for (int i = 0; i < 32; i++) mem[i] = 32'h0000000A;
    mif.req_valid = '0; mif.req_we = '0; mif.req_funct3 = '0;
    mif.req_addr = '0; mif.req_wdata = '0;

    vecs[0]  = mk(0, 0, 3'b010, 32'h08, 32'h0,        32'h0000000A, 0, 2, 0);
    vecs[1]  = mk(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        0, 2, 1);
    vecs[2]  = mk(0, 0, 3'b000, 32'h13, 32'h0,        32'hFFFFFFDE, 0, 2, 0);
    vecs[3]  = mk(0, 0, 3'b100, 32'h13, 32'h0,        32'h000000DE, 0, 2, 0);
    vecs[4]  = mk(0, 0, 3'b001, 32'h12, 32'h0,        32'hFFFFDEAD, 0, 2, 0);
    vecs[5]  = mk(0, 0, 3'b101, 32'h12, 32'h0,        32'h0000DEAD, 0, 2, 0);
    vecs[6]  = mk(0, 0, 3'b000, 32'h10, 32'h0,        32'hFFFFFFEF, 0, 2, 0);
    vecs[7]  = mk(1, 1, 3'b000, 32'h15, 32'h12345655, 32'h0,        0, 3, 2);
    vecs[8]  = mk(1, 1, 3'b001, 32'h1A, 32'h0000BEEF, 32'h0,        0, 3, 2);
    vecs[9]  = mk(1, 0, 3'b010, 32'h18, 32'h0,        32'hBEEF000A, 0, 2, 0);
    vecs[10] = mk(1, 0, 3'b100, 32'h15, 32'h0,        32'h00000055, 0, 2, 0);
    vecs[11] = mk(0, 0, 3'b001, 32'h05, 32'h0,        32'h0,        1, 2, 0);
    vecs[12] = mk(0, 0, 3'b011, 32'h08, 32'h0,        32'h0,        1, 2, 0);
    vecs[13] = mk(1, 1, 3'b100, 32'h20, 32'hFFFFFFFF, 32'h0,        1, 2, 0);
    vecs[14] = mk(0, 1, 3'b010, 32'h22, 32'h11111111, 32'h0,        1, 2, 0);
`ifdef DMEM_BOUNDS_CHECK_EN
    vecs[15] = mk(0, 0, 3'b010, 32'h80, 32'h0,        32'h0,        1, 2, 0);
`else
    vecs[15] = mk(0, 0, 3'b010, 32'h80, 32'h0,        32'h0000000A, 0, 2, 0);
`endif
    vecs[16] = mk(0, 0, 3'b001, 32'h1A, 32'h0,        32'hFFFFBEEF, 0, 2, 0);

    repeat (2) @(negedge CLK);
    check("rst_ready", {30'd0, mif.req_ready}, 32'd0);
    check("rst_rspv",  {30'd0, mif.rsp_valid}, 32'd0);
    check("rst_rdata", mif.rsp_rdata, 32'd0);
    check("rst_err",   {31'd0, mif.rsp_err}, 32'd0);
    check("rst_we",    {31'd0, mif.mem_we}, 32'd0);
    check("rst_addr",  {27'd0, mif.mem_addr}, 32'd0);
    check("rst_wd",    mif.mem_wd, 32'd0);
    check("rst_busy",  {31'd0, mif.busy}, 32'd0);
    RST = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

    check("mem4", mem[4], 32'hDEADBEEF);
    check("mem5", mem[5], 32'h0000550A);
    check("mem6", mem[6], 32'hBEEF000A);
    check("mem8", mem[8], 32'h0000000A);

    // Port 1 request withdrawn while the arbiter is busy must vanish.
    @(negedge CLK);
    drive(0, 1'b1, 1'b0, 3'b010, 32'h0C, 32'h0);
    #1;
    check("drop_p0_ready", {30'd0, mif.req_ready}, 32'd1);
    @(negedge CLK);
    drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    drive(1, 1'b1, 1'b1, 3'b010, 32'h30, 32'hDEADDEAD);
    cnt_we = 0; cnt_r1 = 0; cnt_v1 = 0;
    #1;
    if (mif.req_ready[1]) cnt_r1++;
    @(negedge CLK);
    if (mif.req_ready[1]) cnt_r1++;
    drive(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (mif.mem_we) cnt_we++;
      if (mif.req_ready[1]) cnt_r1++;
      if (mif.rsp_valid[1]) cnt_v1++;
    end
    check("drop_ready1", cnt_r1, 32'd0);
    check("drop_we",     cnt_we, 32'd0);
    check("drop_rspv1",  cnt_v1, 32'd0);
    check("drop_mem12",  mem[12], 32'h0000000A);

    // Reset during the WRITE cycle of an SH.
    drive(0, 1'b1, 1'b1, 3'b001, 32'h04, 32'h0000BEEF);
    #1;
    check("rmw_rst_ready", {30'd0, mif.req_ready}, 32'd1);
    @(negedge CLK);
    drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    @(negedge CLK);
    check("rmw_rst_we_before", {31'd0, mif.mem_we}, 32'd1);
    #1 RST = 1'b1;
    #1;
    check("rmw_rst_we",    {31'd0, mif.mem_we}, 32'd0);
    check("rmw_rst_wd",    mif.mem_wd, 32'd0);
    check("rmw_rst_addr",  {27'd0, mif.mem_addr}, 32'd0);
    check("rmw_rst_rspv",  {30'd0, mif.rsp_valid}, 32'd0);
    check("rmw_rst_rdata", mif.rsp_rdata, 32'd0);
    check("rmw_rst_err",   {31'd0, mif.rsp_err}, 32'd0);
    check("rmw_rst_busy",  {31'd0, mif.busy}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    cnt_v1 = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (mif.rsp_valid != 2'b00) cnt_v1++;
    end
    check("rmw_rst_norsp", cnt_v1, 32'd0);
    check("rmw_rst_mem1",  mem[1], 32'h0000000A);

    // Both ports valid continuously straight out of reset.
    drive(0, 1'b1, 1'b0, 3'b010, 32'h08, 32'h0);
    drive(1, 1'b1, 1'b0, 3'b010, 32'h08, 32'h0);
    ngr = 0; n11 = 0;
    for (int i = 0; i < 40 && ngr < 4; i++) begin
      #1;
      if (mif.req_ready == 2'b11) n11++;
      if (mif.req_ready == 2'b01) begin grants[ngr] = 0; ngr++; end
      else if (mif.req_ready == 2'b10) begin grants[ngr] = 1; ngr++; end
      @(negedge CLK);
    end
    drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    check("rr_ngrants", ngr, 32'd4);
    check("rr_both",    n11, 32'd0);
    for (int i = 0; i < 4; i++)
      check($sformatf("rr_g%0d", i), (i < ngr) ? grants[i] : -1, i % 2);
    repeat (4) @(negedge CLK);
    check("rr_idle", {31'd0, mif.busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
